adc_sensor_sampler: RTL
=======================

Name: adc_sensor_sampler

Overview:
Upstream feeder for the sensor display path. Periodically reads a 12-bit serial ADC (ADCS7476-style, 16-bit frame) over a 3-wire SPI link and averages 2^AVG_LOG2 conversions. It scales the average to engineering units (default millivolts at 3.3 V full scale) and saturates to the 4-digit display range. Its 16-bit value output drives the binary input of the BCD/7-segment display controller directly.

Parameters:
CLK_DIV, 2, clk cycles per SCLK half-period (min 1)
SAMPLE_PERIOD, 5000000, clk cycles between conversion triggers (must exceed 34*CLK_DIV+4)
AVG_LOG2, 3, log2 of samples averaged per output update (0..6)
SCALE_MUL, 3300, multiplier applied to averaged 12-bit code (16-bit unsigned)
SCALE_SHIFT, 12, right shift after multiply
MAX_VALUE, 9999, saturation ceiling for value

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
adc_sdata  in  1  ADC serial data, MSB first
adc_cs_n  out  1  ADC chip select, active low
adc_sclk  out  1  SPI clock, idles high
value  out  16  scaled, averaged, saturated sensor reading (binary)
value_valid  out  1  one-cycle pulse when value updates
busy  out  1  high from trigger until the end of ACCUM/SCALE

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: adc_cs_n=1, adc_sclk=1, value=0, value_valid=0, busy=0, accumulator=0, sample count=0, period timer=0, FSM=IDLE.
- Period timer counts 0..SAMPLE_PERIOD-1 and wraps. The trigger is the cycle it equals SAMPLE_PERIOD-1. A trigger seen outside IDLE is dropped, not queued.
- FSM states: IDLE -> CONV -> QUIET -> ACCUM -> (SCALE on last sample, else IDLE); SCALE -> IDLE.
- IDLE: on trigger, adc_cs_n<=0 and busy<=1 on the next edge, then enter CONV.
- CONV: 16 bits. Each bit drives adc_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
- adc_sdata is sampled on the clk edge that drives adc_sclk from 0 to 1, and shifted into a 16-bit register MSB first.
- After the 16th high phase, adc_cs_n<=1 and the FSM enters QUIET.
- QUIET: hold adc_cs_n=1 and adc_sclk=1 for CLK_DIV cycles.
- ACCUM (1 cycle): sample = shift[11:0]; shift[15:12] is ignored whatever its contents. acc += sample; count += 1.
  - If count wraps (reaches 2^AVG_LOG2), go to SCALE. Otherwise go to IDLE and drop busy.
- Accumulator width is 12+AVG_LOG2 bits and never overflows.
- SCALE (1 cycle): avg = acc >> AVG_LOG2; prod = avg*SCALE_MUL (28 bits, unsigned); res = prod >> SCALE_SHIFT (truncate).
  - value <= (res > MAX_VALUE) ? MAX_VALUE : res[15:0].
  - value_valid=1 for exactly that next cycle.
  - acc and count clear; busy drops.
- Latency: value updates 1 cycle after ACCUM of the final sample; value_valid is coincident with the new value.
- value holds between updates; it never glitches during conversions.
- adc_sclk and adc_cs_n are driven from registers (no combinational outputs).
- Reset mid-operation (any state): next edge gives adc_cs_n=1 and adc_sclk=1; the partial frame and accumulated samples are discarded; no value_valid. The timer restarts at 0.
- Reset and trigger in the same cycle: reset wins.

Decomposition:
- Shared package: ADC_FRAME_BITS=16, ADC_DATA_BITS=12, DISPLAY_MAX=9999, FSM state encoding (IDLE, CONV, QUIET, ACCUM, SCALE).
- One natural sub-module: spi_adc_rx. It owns the SCLK divider, bit counter and 16-bit shift register, with a start/done handshake: start is a one-cycle pulse in IDLE; done is a one-cycle pulse at the end of QUIET with data[15:0] stable.
- Averaging, scaling and saturation stay in the top.

Test Plan:
(Bench parameters unless noted: CLK_DIV=2, SAMPLE_PERIOD=100, AVG_LOG2=2, SCALE_MUL=3300, SCALE_SHIFT=12.)
1. Reset held 10 cycles, then released -> adc_cs_n=1, adc_sclk=1, value=0, value_valid=0, busy=0. The first adc_cs_n fall occurs exactly 100 cycles after release.
2. ADC model returns frame 0x0ABC for 4 conversions -> exactly 64 SCLK rising edges, then one value_valid pulse with value=2213 (2748*3300>>12).
3. Frames 0x0000, 0x0004, 0x0008, 0x000C -> avg 6, value=4. No value_valid after the first three conversions.
4. Frames 0xFFFF x4 (leading nibble 1s) -> value=3299 (upper nibble ignored). Rerun with SCALE_MUL=12000 -> value=9999 (saturated from 11997).
5. Reset asserted during the 5th SCLK of the 2nd conversion -> next cycle adc_cs_n=1 and adc_sclk=1; no value_valid. The next 4 frames of 0x0400 yield value=825 (accumulator was cleared).
6. SAMPLE_PERIOD=40 with CLK_DIV=2 (trigger overlaps busy) -> overlapping triggers are dropped. No frame is ever shorter than 16 SCLKs, and the CS high time is at least 2 cycles.

Source files
------------

// File: rtl/adc_sensor_sampler_pkg.sv
// Shared constants, state encodings and helpers for the ADC sensor sampler.
package adc_sensor_sampler_pkg;

    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_DATA_BITS  = 12;
    localparam int DISPLAY_MAX    = 9999;
    localparam int PROD_BITS      = 28;

    // Sequencing of one conversion as seen by the averaging logic.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_QUIET = 3'd2,
        ST_ACCUM = 3'd3,
        ST_SCALE = 3'd4
    } sampler_state_t;

    // Phases of the serial receiver.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_LOW   = 2'd1,
        RX_HIGH  = 2'd2,
        RX_QUIET = 2'd3
    } rx_state_t;

    // Clamp a scaled result to the display ceiling.
    function automatic logic [15:0] saturate(input logic [PROD_BITS-1:0] res,
                                             input logic [PROD_BITS-1:0] ceil);
        return (res > ceil) ? ceil[15:0] : res[15:0];
    endfunction

endpackage

// File: rtl/adc_sensor_sampler_spi_adc_rx.sv
// Three-wire SPI receiver for a 16-bit ADC frame.
// Handshake: start_i is a one-cycle request accepted only while idle;
// frame_end_o pulses in the cycle before CS rises; done_o pulses in the
// last quiet cycle, with data_o stable from then until the next start_i.
module spi_adc_rx
    import adc_sensor_sampler_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        sdata_i,
    output logic        cs_n_o,
    output logic        sclk_o,
    output logic        frame_end_o,
    output logic        done_o,
    output logic [15:0] data_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0] BIT_LAST = 4'(ADC_FRAME_BITS - 1);

    rx_state_t        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       bit_q, bit_d;
    logic [15:0]      shift_q, shift_d;
    logic             cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             div_last;

    assign div_last = (div_q == DIV_LAST);
    assign cs_n_o   = cs_n_q;
    assign sclk_o   = sclk_q;
    assign data_o   = shift_q;

    // Receiver registers; pins idle with CS and SCLK high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RX_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
        end
    end

    // Phase sequencing: each bit is CLK_DIV cycles low then CLK_DIV high;
    // data is captured on the edge that raises SCLK.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        frame_end_o = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (start_i) begin
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = RX_LOW;
                end
            end
            RX_LOW: begin
                if (div_last) begin
                    sclk_d  = 1'b1;
                    shift_d = {shift_q[14:0], sdata_i};
                    div_d   = '0;
                    state_d = RX_HIGH;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            RX_HIGH: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        cs_n_d      = 1'b1;
                        frame_end_o = 1'b1;
                        state_d     = RX_QUIET;
                    end else begin
                        sclk_d  = 1'b0;
                        bit_d   = bit_q + 1'b1;
                        state_d = RX_LOW;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            RX_QUIET: begin
                if (div_last) begin
                    done_o  = 1'b1;
                    div_d   = '0;
                    state_d = RX_IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/adc_sensor_sampler.sv
// Periodic ADC sampler: triggers conversions, averages 2^AVG_LOG2 codes,
// scales to engineering units and saturates to the display range.
module adc_sensor_sampler
    import adc_sensor_sampler_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_PERIOD = 5000000,
    parameter int AVG_LOG2      = 3,
    parameter int SCALE_MUL     = 3300,
    parameter int SCALE_SHIFT   = 12,
    parameter int MAX_VALUE     = DISPLAY_MAX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        adc_sdata_i,
    output logic        adc_cs_n_o,
    output logic        adc_sclk_o,
    output logic [15:0] value_o,
    output logic        value_valid_o,
    output logic        busy_o
);

    localparam int N_AVG = 1 << AVG_LOG2;
    localparam int ACC_W = ADC_DATA_BITS + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TMR_W = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(N_AVG - 1);
    localparam logic [PROD_BITS-1:0] MUL_W    = PROD_BITS'(SCALE_MUL);
    localparam logic [PROD_BITS-1:0] CEIL_W   = PROD_BITS'(MAX_VALUE);

    sampler_state_t     state_q, state_d;
    logic [TMR_W-1:0]   timer_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        value_q, value_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic               trigger;
    logic               rx_start;
    logic               rx_frame_end;
    logic               rx_done;
    logic [15:0]        rx_data;
    logic [ADC_DATA_BITS-1:0] avg;
    logic [PROD_BITS-1:0]     prod;
    logic [PROD_BITS-1:0]     res;
    logic               unused_hdr;

    assign trigger       = (timer_q == TMR_LAST);
    assign value_o       = value_q;
    assign value_valid_o = valid_q;
    assign busy_o        = busy_q;

    // The frame's leading nibble carries no data.
    assign unused_hdr = ^rx_data[15:12];

    // Averaging and scaling of the completed accumulation.
    assign avg  = ADC_DATA_BITS'(acc_q >> AVG_LOG2);
    assign prod = PROD_BITS'(avg) * MUL_W;
    assign res  = prod >> SCALE_SHIFT;

    spi_adc_rx #(
        .CLK_DIV(CLK_DIV)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .start_i    (rx_start),
        .sdata_i    (adc_sdata_i),
        .cs_n_o     (adc_cs_n_o),
        .sclk_o     (adc_sclk_o),
        .frame_end_o(rx_frame_end),
        .done_o     (rx_done),
        .data_o     (rx_data)
    );

    // Free-running period timer; restarts from zero on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else if (trigger) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // Sequencer and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; triggers arriving outside IDLE are simply ignored.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        value_d  = value_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        rx_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    rx_start = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_CONV;
                end
            end
            ST_CONV: begin
                if (rx_frame_end) begin
                    state_d = ST_QUIET;
                end
            end
            ST_QUIET: begin
                if (rx_done) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + ACC_W'(rx_data[ADC_DATA_BITS-1:0]);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SCALE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_SCALE: begin
                value_d = saturate(res, CEIL_W);
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
